// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: multi-cycle ALU. The operation is processed SLICE bits per
// clock through a registered carry chain, so one slice datapath serves
// N = WIDTH/SLICE cycles.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  request pulse; sampled only when not busy
//   a, b, CarryIn, ALUOp   operands and op, captured on the accepting edge
//   busy                   high while an operation is running
//   done                   one-cycle pulse; Result and flags valid from here
//   Result, CarryOut, Zero, Overflow   held until the next done or reset
module alu_nbit_seq #(
  parameter int WIDTH = 6,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             CarryIn,
  input  logic [3:0]       ALUOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Zero,
  output logic             Overflow
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, part_q;
  logic [3:0]       op_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q, co_q, zero_q, ovf_q;
  logic [WIDTH-1:0] res_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign Result   = res_q;
  assign CarryOut = co_q;
  assign Zero     = zero_q;
  assign Overflow = ovf_q;

  // Slice datapath
  logic [SLICE-1:0] as, bs, sl_sum, sl_res;
  logic             c, c_top, c_out, is_arith, ovf, last;
  logic [WIDTH-1:0] full_d, fin_res_d;
  int               base;

  always_comb begin
    base     = int'(cnt_q) * SLICE;
    as       = a_q[base +: SLICE];
    bs       = b_q[base +: SLICE];
    c        = carry_q;
    c_top    = carry_q;
    sl_sum   = '0;
    // Ripple within the slice; c_top keeps the carry into the slice's top bit,
    // which on the last slice is the carry into the result MSB.
    for (int j = 0; j < SLICE; j++) begin
      if (j == SLICE - 1) c_top = c;
      sl_sum[j] = as[j] ^ bs[j] ^ c;
      c         = (as[j] & bs[j]) | (c & (as[j] ^ bs[j]));
    end
    c_out    = c;
    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT);
    case (op_q)
      OP_AND:                 sl_res = as & bs;
      OP_OR:                  sl_res = as | bs;
      OP_NOR:                 sl_res = ~(as | bs);
      OP_ADD, OP_SUB, OP_SLT: sl_res = sl_sum;
      default:                sl_res = '0;
    endcase
    full_d = part_q;
    full_d[base +: SLICE] = sl_res;
    ovf    = is_arith & (c_top ^ c_out);
    // SLT: true sign of a-b is the sum MSB corrected by overflow
    if (op_q == OP_SLT) fin_res_d = WIDTH'(sl_sum[SLICE-1] ^ ovf);
    else                fin_res_d = full_d;
    last = (cnt_q == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          part_q  <= full_d;
          carry_q <= c_out;
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= fin_res_d;
            co_q    <= is_arith & c_out;
            ovf_q   <= ovf;
            zero_q  <= (fin_res_d == '0);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        // IDLE and DONE both accept a new request
        default: begin
          state_q <= S_IDLE;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            // Subtraction is a + ~b + 1: invert b once at capture
            b_q     <= (ALUOp == OP_SUB || ALUOp == OP_SLT) ? ~b : b;
            op_q    <= ALUOp;
            carry_q <= (ALUOp == OP_ADD) ? CarryIn :
                       (ALUOp == OP_SUB || ALUOp == OP_SLT);
            cnt_q   <= '0;
            part_q  <= '0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_nbit_seq.sv
module tb_alu_nbit_seq;
  localparam int W  = 6;
  localparam int ND = 4;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0] op = '0;

  logic busy_w [ND];
  logic done_w [ND];
  logic co_w   [ND];
  logic z_w    [ND];
  logic v_w    [ND];
  logic [W-1:0] res_w [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int SL = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : 6;
    alu_nbit_seq #(.WIDTH(W), .SLICE(SL)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .CarryIn(cin), .ALUOp(op), .busy(busy_w[g]), .done(done_w[g]),
      .Result(res_w[g]), .CarryOut(co_w[g]), .Zero(z_w[g]),
      .Overflow(v_w[g]));
  end

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 6 : (k == 1) ? 3 : (k == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d", nm, k, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mc, input logic [3:0] mop,
                       output logic [W-1:0] r, output logic co,
                       output logic v, output logic z);
    int ua, ub, sa, sb, s;
    ua = int'(ma); ub = int'(mb);
    sa = ma[W-1] ? ua - 64 : ua;
    sb = mb[W-1] ? ub - 64 : ub;
    r = '0; co = 1'b0; v = 1'b0;
    case (mop)
      4'b0000: r = ma & mb;
      4'b0001: r = ma | mb;
      4'b1100: r = ~(ma | mb);
      4'b0010: begin
        s  = ua + ub + int'(mc);
        r  = W'(s);
        co = (s >= 64);
        v  = (sa + sb + int'(mc) > 31) || (sa + sb + int'(mc) < -32);
      end
      4'b0110, 4'b0111: begin
        co = (ua >= ub);
        v  = (sa - sb > 31) || (sa - sb < -32);
        r  = (mop == 4'b0111) ? W'(sa < sb ? 1 : 0) : W'(ua - ub + 64);
      end
      default: r = '0;
    endcase
    z = (r == '0);
  endtask

  // Issue one op to all instances and check results, latency, pulse width
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [3:0] top,
                        input logic [W-1:0] er, input logic ec,
                        input logic ev, input logic ez);
    int lat [ND];
    int dc [ND];
    int bc [ND];
    @(negedge clk);
    a = ta; b = tb; cin = tc; op = top; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 4'($urandom);
    for (int k = 0; k < ND; k++) begin
      lat[k] = 0; dc[k] = 0; bc[k] = int'(busy_w[k]);
    end
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) begin
        if (done_w[k]) begin dc[k]++; if (lat[k] == 0) lat[k] = cyc; end
        if (busy_w[k]) bc[k]++;
      end
    end
    for (int k = 0; k < ND; k++) begin
      chk("result",   k, 32'(res_w[k]), 32'(er));
      chk("carryout", k, 32'(co_w[k]),  32'(ec));
      chk("overflow", k, 32'(v_w[k]),   32'(ev));
      chk("zero",     k, 32'(z_w[k]),   32'(ez));
      chk("latency",  k, 32'(lat[k]),   32'(lat_of(k)));
      chk("donewidth", k, 32'(dc[k]),   32'd1);
      chk("busycycles", k, 32'(bc[k]),  32'(lat_of(k)));
    end
  endtask

  task automatic wait_done0(input int from, input int maxc, output int at);
    at = -1;
    for (int cyc = from; cyc <= maxc; cyc++) begin
      @(posedge clk); #1;
      if (done_w[0]) begin at = cyc; break; end
    end
  endtask

  typedef struct {
    logic [W-1:0] va, vb;
    logic         vc;
    logic [3:0]   vop;
    logic [W-1:0] er;
    logic         ec, ev, ez;
  } vec_t;

  initial begin
    vec_t vt [11];
    logic [W-1:0] mr;
    logic mc, mv, mz;
    int at;
    int dcnt;

    vt[0]  = '{6'd25, 6'd20, 1'b0, 4'b0010, 6'd45, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{6'd10, 6'd10, 1'b0, 4'b0110, 6'd0,  1'b1, 1'b0, 1'b1};
    vt[2]  = '{6'd63, 6'd0,  1'b1, 4'b0010, 6'd0,  1'b1, 1'b0, 1'b1};
    vt[3]  = '{6'd62, 6'd3,  1'b0, 4'b0111, 6'd1,  1'b1, 1'b0, 1'b0};
    vt[4]  = '{6'd3,  6'd62, 1'b0, 4'b0111, 6'd0,  1'b0, 1'b0, 1'b1};
    vt[5]  = '{6'd31, 6'd32, 1'b0, 4'b0111, 6'd0,  1'b0, 1'b1, 1'b1};
    vt[6]  = '{6'd42, 6'd51, 1'b0, 4'b0000, 6'd34, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{6'd42, 6'd51, 1'b1, 4'b0001, 6'd59, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{6'd42, 6'd51, 1'b0, 4'b1100, 6'd4,  1'b0, 1'b0, 1'b0};
    vt[9]  = '{6'd42, 6'd51, 1'b1, 4'b1111, 6'd0,  1'b0, 1'b0, 1'b1};
    vt[10] = '{6'd7,  6'd1,  1'b1, 4'b0010, 6'd9,  1'b0, 1'b0, 1'b0};

    // Reset state
    #2;
    for (int k = 0; k < ND; k++) begin
      chk("rst_busy", k, 32'(busy_w[k]), 32'd0);
      chk("rst_done", k, 32'(done_w[k]), 32'd0);
      chk("rst_res",  k, 32'(res_w[k]),  32'd0);
      chk("rst_flags", k, 32'({co_w[k], z_w[k], v_w[k]}), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 11; i++)
      run_op(vt[i].va, vt[i].vb, vt[i].vc, vt[i].vop,
             vt[i].er, vt[i].ec, vt[i].ev, vt[i].ez);

    // Random ops against the model
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      logic [3:0] rop;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      case ($urandom_range(0, 6))
        0: rop = 4'b0000; 1: rop = 4'b0001; 2: rop = 4'b0010;
        3: rop = 4'b0110; 4: rop = 4'b0111; 5: rop = 4'b1100;
        default: rop = 4'($urandom);
      endcase
      model(ra, rb, rc, rop, mr, mc, mv, mz);
      run_op(ra, rb, rc, rop, mr, mc, mv, mz);
    end

    // start mid-RUN is ignored (checked on the SLICE=1 instance)
    @(negedge clk);
    a = 6'd25; b = 6'd20; cin = 1'b0; op = 4'b0010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); a = 6'd1; b = 6'd1; op = 4'b0110; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done0(3, 12, at);
    chk("midrun_lat", 0, 32'(at), 32'd6);
    chk("midrun_res", 0, 32'(res_w[0]), 32'd45);
    repeat (10) @(posedge clk);

    // start during the DONE cycle is accepted
    @(negedge clk);
    a = 6'd10; b = 6'd10; op = 4'b0110; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done0(1, 10, at);
    chk("b2b_lat1", 0, 32'(at), 32'd6);
    chk("b2b_res1", 0, 32'(res_w[0]), 32'd0);
    chk("b2b_z1",   0, 32'(z_w[0]), 32'd1);
    a = 6'd5; b = 6'd7; cin = 1'b0; op = 4'b0010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("b2b_busy", 0, 32'(busy_w[0]), 32'd1);
    chk("b2b_hold", 0, 32'(res_w[0]), 32'd0);
    wait_done0(1, 10, at);
    chk("b2b_lat2", 0, 32'(at), 32'd6);
    chk("b2b_res2", 0, 32'(res_w[0]), 32'd12);
    repeat (5) @(posedge clk);
    #1 chk("hold_res", 0, 32'(res_w[0]), 32'd12);

    // Reset in cycle 3 of RUN: outputs clear at once, no done pulse
    @(negedge clk);
    a = 6'd25; b = 6'd20; cin = 1'b0; op = 4'b0010; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      chk("abort_busy", k, 32'(busy_w[k]), 32'd0);
      chk("abort_res",  k, 32'(res_w[k]),  32'd0);
      chk("abort_flags", k, 32'({done_w[k], co_w[k], z_w[k], v_w[k]}), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    dcnt = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < ND; k++) if (done_w[k] || busy_w[k]) dcnt++;
    end
    chk("abort_nodone", 0, 32'(dcnt), 32'd0);
    run_op(6'd1, 6'd1, 1'b0, 4'b0010, 6'd2, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
endmodule
